intl_fault_mgr: RTL and testbench

INTL_FAULT_MGR -- requirements
Module: intl_fault_mgr

---
 rtl/intl_pkg.sv | 23 ++
 rtl/intl_debounce.sv | 40 ++++
 rtl/intl_fault_mgr.sv | 164 ++++++++++++++++
 tb/tb_intl_fault_mgr.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intl_pkg.sv
// Shared definitions for the interlock fault manager: FSM encoding, size defaults
// and the bit position of each interlock source in the flag vector.
package intl_pkg;

    localparam int N_SRC_DEF = 8;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_TRIPPED = 2'd1,
        ST_CLEAR   = 2'd2
    } intl_state_e;

    localparam int SRC_OSC   = 0;
    localparam int SRC_OC    = 1;
    localparam int SRC_OV    = 2;
    localparam int SRC_UV    = 3;
    localparam int SRC_OT    = 4;
    localparam int SRC_GF    = 5;
    localparam int SRC_DESAT = 6;
    localparam int SRC_EXT   = 7;

endpackage

// File: rtl/intl_debounce.sv
// One interlock source: saturating run-length counter of unmasked high samples,
// qualifying the source once the run has lasted D extra samples.
module intl_debounce
    import intl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flag,
    input  logic             i_mask,
    input  logic [CNT_W-1:0] i_debounce,
    output logic             o_active,
    output logic             o_qual
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_active;
    logic [CNT_W-1:0] r_cnt;

    assign w_active = i_flag & ~i_mask;

    // Run-length counter; any masked or low sample restarts the run
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!w_active) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_active = w_active;
    assign o_qual   = w_active & (r_cnt >= i_debounce);

endmodule

// File: rtl/intl_fault_mgr.sv
// Interlock fault manager: debounces N_SRC fault flags, latches them on trip,
// gates the power-stage permissive and runs the operator clear handshake.
module intl_fault_mgr
    import intl_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_flag,
    input  logic [N_SRC-1:0] i_mask,
    input  logic [CNT_W-1:0] i_debounce,
    input  logic [CNT_W-1:0] i_clr_time,
    input  logic             i_clr,
    input  logic             i_en_req,
    output logic [N_SRC-1:0] o_fault_latched,
    output logic [N_SRC-1:0] o_first_fault,
    output logic             o_intl,
    output logic             o_out_en,
    output logic             o_src_clr,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_trip_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [N_SRC-1:0] w_qual;
    logic [N_SRC-1:0] w_active;
    logic             w_any_qual;

    intl_state_e      r_state;
    logic [N_SRC-1:0] r_latched;
    logic [N_SRC-1:0] r_first;
    logic             r_intl;
    logic             r_out_en;
    logic             r_src_clr;
    logic [CNT_W-1:0] r_clr_cnt;
    logic [CNT_W-1:0] r_trip_cnt;

    intl_state_e      w_state_nxt;
    logic [N_SRC-1:0] w_latched_nxt;
    logic [N_SRC-1:0] w_first_nxt;
    logic             w_intl_nxt;
    logic             w_out_en_nxt;
    logic             w_src_clr_nxt;
    logic [CNT_W-1:0] w_clr_cnt_nxt;
    logic [CNT_W-1:0] w_trip_cnt_nxt;

    genvar g;
    generate
        for (g = 0; g < N_SRC; g++) begin : g_src
            intl_debounce #(
                .CNT_W(CNT_W)
            ) u_debounce (
                .i_clk     (i_clk),
                .i_rst     (i_rst),
                .i_flag    (i_flag[g]),
                .i_mask    (i_mask[g]),
                .i_debounce(i_debounce),
                .o_active  (w_active[g]),
                .o_qual    (w_qual[g])
            );
        end
    endgenerate

    assign w_any_qual = |w_qual;

    // Next-state and next-output decode for the trip / clear sequence
    always_comb begin
        w_state_nxt    = r_state;
        w_latched_nxt  = r_latched;
        w_first_nxt    = r_first;
        w_intl_nxt     = r_intl;
        w_src_clr_nxt  = 1'b0;
        w_clr_cnt_nxt  = r_clr_cnt;
        w_trip_cnt_nxt = r_trip_cnt;
        w_out_en_nxt   = i_en_req & (r_state == ST_NORMAL) & ~w_any_qual;

        case (r_state)
            ST_NORMAL: begin
                // A coincident i_clr is meaningless here, so qualification wins
                if (w_any_qual) begin
                    w_state_nxt   = ST_TRIPPED;
                    w_latched_nxt = w_qual;
                    w_first_nxt   = w_qual;
                    w_intl_nxt    = 1'b1;
                    if (r_trip_cnt != '1) begin
                        w_trip_cnt_nxt = r_trip_cnt + CNT_ONE;
                    end else begin
                        w_trip_cnt_nxt = r_trip_cnt;
                    end
                end else begin
                    w_state_nxt = ST_NORMAL;
                end
            end
            ST_TRIPPED: begin
                w_latched_nxt = r_latched | w_qual;
                if (i_clr) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                    w_src_clr_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_TRIPPED;
                end
            end
            ST_CLEAR: begin
                if (r_clr_cnt == i_clr_time) begin
                    if (w_active == '0) begin
                        w_state_nxt   = ST_NORMAL;
                        w_latched_nxt = '0;
                        w_first_nxt   = '0;
                        w_intl_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = ST_TRIPPED;
                    end
                end else begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = r_clr_cnt + CNT_ONE;
                    w_src_clr_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_NORMAL;
                w_latched_nxt = '0;
                w_first_nxt   = '0;
                w_intl_nxt    = 1'b0;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_NORMAL;
            r_latched  <= '0;
            r_first    <= '0;
            r_intl     <= 1'b0;
            r_out_en   <= 1'b0;
            r_src_clr  <= 1'b0;
            r_clr_cnt  <= '0;
            r_trip_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_latched  <= w_latched_nxt;
            r_first    <= w_first_nxt;
            r_intl     <= w_intl_nxt;
            r_out_en   <= w_out_en_nxt;
            r_src_clr  <= w_src_clr_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_trip_cnt <= w_trip_cnt_nxt;
        end
    end

    assign o_fault_latched = r_latched;
    assign o_first_fault   = r_first;
    assign o_intl          = r_intl;
    assign o_out_en        = r_out_en;
    assign o_src_clr       = r_src_clr;
    assign o_state         = r_state;
    assign o_trip_cnt      = r_trip_cnt;

endmodule

// File: tb/tb_intl_fault_mgr.sv
// Self-checking bench for intl_fault_mgr: per-scenario tasks push expected output
// snapshots to a scoreboard queue and compare them as the DUT produces each cycle.
module tb_intl_fault_mgr;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_flag;
    logic [7:0]  i_mask;
    logic [15:0] i_debounce;
    logic [15:0] i_clr_time;
    logic        i_clr;
    logic        i_en_req;
    logic [7:0]  o_fault_latched;
    logic [7:0]  o_first_fault;
    logic        o_intl;
    logic        o_out_en;
    logic        o_src_clr;
    logic [1:0]  o_state;
    logic [15:0] o_trip_cnt;

    // Snapshot layout: latched, first, intl, out_en, src_clr, state, trip_cnt
    logic [36:0] w_obs;
    logic [36:0] exp_q[$];
    logic [36:0] e;
    int          n_checks;
    int          n_errors;

    assign w_obs = {o_fault_latched, o_first_fault, o_intl, o_out_en, o_src_clr, o_state, o_trip_cnt};

    intl_fault_mgr #(.N_SRC(8), .CNT_W(16)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_flag         (i_flag),
        .i_mask         (i_mask),
        .i_debounce     (i_debounce),
        .i_clr_time     (i_clr_time),
        .i_clr          (i_clr),
        .i_en_req       (i_en_req),
        .o_fault_latched(o_fault_latched),
        .o_first_fault  (o_first_fault),
        .o_intl         (o_intl),
        .o_out_en       (o_out_en),
        .o_src_clr      (o_src_clr),
        .o_state        (o_state),
        .o_trip_cnt     (o_trip_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [36:0] pk(input logic [7:0] lat, input logic [7:0] first,
                                       input logic intl, input logic oe, input logic sc,
                                       input logic [1:0] st, input logic [15:0] trip);
        return {lat, first, intl, oe, sc, st, trip};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_flag = 8'h00;
        i_mask = 8'h00;
        i_clr = 1'b0;
        i_en_req = 1'b1;
        i_debounce = 16'd0;
        i_clr_time = 16'd0;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_flag = 8'h01;
        i_mask = 8'h00;
        i_clr = 1'b0;
        i_en_req = 1'b1;
        i_debounce = 16'd0;
        i_clr_time = 16'd0;
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_errors++;
                $display("FAIL reset_hold c%0d: got %h expected %h", c, w_obs, e);
            end
        end
        i_flag = 8'h00;
        i_rst = 1'b0;
        exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0));
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (w_obs !== e) begin
            n_errors++;
            $display("FAIL reset_release: got %h expected %h", w_obs, e);
        end
    endtask

    task automatic test_debounce();
        do_reset();
        i_debounce = 16'd3;
        for (int c = 0; c < 9; c++) begin
            i_flag = (c < 3 || c >= 5) ? 8'h01 : 8'h00;
            if (c == 8) exp_q.push_back(pk(8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 2'd1, 16'd1));
            else        exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_errors++;
                $display("FAIL debounce c%0d: got %h expected %h", c, w_obs, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        i_flag = 8'h06;
        exp_q.push_back(pk(8'h06, 8'h06, 1'b1, 1'b0, 1'b0, 2'd1, 16'd1));
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (w_obs !== e) begin
            n_errors++;
            $display("FAIL simultaneous: got %h expected %h", w_obs, e);
        end
    endtask

    task automatic test_accumulate();
        do_reset();
        // Coincident i_clr in NORMAL must lose to qualification
        i_flag = 8'h01;
        i_clr = 1'b1;
        exp_q.push_back(pk(8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 2'd1, 16'd1));
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        i_flag = 8'h09;
        exp_q.push_back(pk(8'h09, 8'h01, 1'b1, 1'b0, 1'b0, 2'd1, 16'd1));
        for (int c = 0; c < 2; c++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_errors++;
                $display("FAIL accumulate s%0d: got %h expected %h", c, w_obs, e);
            end
            if (c == 0) tick();
        end
    endtask

    task automatic test_clear();
        do_reset();
        i_clr_time = 16'd5;
        i_flag = 8'h01;
        tick();
        i_flag = 8'h00;
        i_clr = 1'b1;
        // Entry edge plus five more counting cycles keep o_src_clr high
        for (int c = 0; c < 8; c++) begin
            if (c < 6)       exp_q.push_back(pk(8'h01, 8'h01, 1'b1, 1'b0, 1'b1, 2'd2, 16'd1));
            else if (c == 6) exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 16'd1));
            else             exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 16'd1));
            tick();
            i_clr = (c == 2) ? 1'b1 : 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_errors++;
                $display("FAIL clear_ok c%0d: got %h expected %h", c, w_obs, e);
            end
        end
        i_clr = 1'b0;
        i_flag = 8'h01;
        exp_q.push_back(pk(8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 2'd1, 16'd2));
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (w_obs !== e) begin
            n_errors++;
            $display("FAIL clear_retrip: got %h expected %h", w_obs, e);
        end
        i_clr = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c < 6) exp_q.push_back(pk(8'h01, 8'h01, 1'b1, 1'b0, 1'b1, 2'd2, 16'd2));
            else       exp_q.push_back(pk(8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 2'd1, 16'd2));
            tick();
            i_clr = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_errors++;
                $display("FAIL clear_fail c%0d: got %h expected %h", c, w_obs, e);
            end
        end
    endtask

    task automatic test_mask();
        do_reset();
        i_mask = 8'h01;
        i_flag = 8'h01;
        for (int c = 0; c < 7; c++) begin
            case (c)
                0, 1, 2: exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0));
                3, 4:    exp_q.push_back(pk(8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 2'd1, 16'd1));
                5:       exp_q.push_back(pk(8'h01, 8'h01, 1'b1, 1'b0, 1'b1, 2'd2, 16'd1));
                default: exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 16'd1));
            endcase
            i_mask = (c == 3) ? 8'h00 : 8'h01;
            i_clr = (c == 5) ? 1'b1 : 1'b0;
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e) begin
                n_errors++;
                $display("FAIL mask c%0d: got %h expected %h", c, w_obs, e);
            end
        end
        i_clr = 1'b0;
        exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 16'd1));
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (w_obs !== e) begin
            n_errors++;
            $display("FAIL mask_after_clear: got %h expected %h", w_obs, e);
        end
    endtask

    task automatic test_reset_in_clear();
        do_reset();
        i_clr_time = 16'd5;
        i_flag = 8'h01;
        tick();
        i_flag = 8'h00;
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        tick();
        #2;
        i_rst = 1'b1;
        exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0));
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (w_obs !== e) begin
            n_errors++;
            $display("FAIL reset_async: got %h expected %h", w_obs, e);
        end
        tick();
        i_rst = 1'b0;
        exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0));
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (w_obs !== e) begin
            n_errors++;
            $display("FAIL reset_after_clear: got %h expected %h", w_obs, e);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        i_rst = 1'b1;
        i_flag = 8'h00;
        i_mask = 8'h00;
        i_clr = 1'b0;
        i_en_req = 1'b0;
        i_debounce = 16'd0;
        i_clr_time = 16'd0;
        #2;
        test_reset();
        test_debounce();
        test_simultaneous();
        test_accumulate();
        test_clear();
        test_mask();
        test_reset_in_clear();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
